if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry in-order instruction queue between fetch (IF) and decode (ID).
- Decouples fetch from decode stalls, provides flush for branch/jump redirect, and carries a valid bit per entry.
- Presents a bubble on its outputs when it is empty.

Parameters:
- REG_NUM_BITWIDTH, 5, register-index width; carried for interface consistency, unused internally.
- WORD_BITWIDTH, 32, width of pc and instruction.
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_BITWIDTH, $clog2(DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_valid  input  1  IF offers {pc, instruction} this cycle.
- if_ready  output  1  queue accepts a push this cycle; equals !full.
- pc  input  WORD_BITWIDTH  fetch PC.
- instruction  input  WORD_BITWIDTH  fetched instruction word.
- hz_stall  input  1  ID stall from the hazard unit; blocks pop.
- flush  input  1  redirect; discard all entries.
- id_valid  output  1  head entry is valid (queue not empty).
- id_wt_pc  output  WORD_BITWIDTH  PC of head entry.
- if_id_instruction  output  WORD_BITWIDTH  instruction of head entry.
- occupancy  output  CNT_BITWIDTH  number of valid entries, 0..DEPTH.

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high.
- Storage:
  - Circular buffer with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, plus a count register.
  - Pointers wrap from DEPTH-1 to 0.
- Reset (async, immediate):
  - wr_ptr=0, rd_ptr=0, count=0, all entries cleared to 0.
  - Outputs: id_valid=0, occupancy=0, if_ready=1, id_wt_pc=0, if_id_instruction = bubble value.
- push = if_valid & if_ready & !flush. The entry is written at wr_ptr and wr_ptr increments.
- pop = id_valid & !hz_stall & !flush. rd_ptr increments.
- count update: push&pop -> unchanged; push only -> +1; pop only -> -1.
- if_ready = (count != DEPTH).
  - Depends on registered state only; there is no combinational path from hz_stall or flush.
  - When full, a push is refused even if a pop occurs in the same cycle.
- id_valid = (count != 0). occupancy = count.
- Head outputs:
  - When id_valid=1: id_wt_pc and if_id_instruction equal the entry at rd_ptr.
  - When empty: id_wt_pc=0 and if_id_instruction = bubble value.
- Latency: a word pushed into an empty queue appears at the outputs, with id_valid=1, in the cycle after the push edge. This is the same 1-cycle latency as the previous IF/ID register.
- Stall: with hz_stall=1 the head and its outputs hold; pushes continue until full.
- Flush:
  - Synchronous.
  - Next edge: count=0, rd_ptr=wr_ptr=0.
  - Any same-cycle push or pop is suppressed; flush has priority over everything except rst.
- Ordering: strictly FIFO; no entry is duplicated or dropped except by flush or rst.
- Reset mid-operation: all in-flight entries are lost; state equals post-reset.

Optional Feature:
- Macro: IF_ID_QUEUE_BUBBLE_NOP_EN.
- Defined: bubble value is the RV32I canonical NOP, 32'h00000013 (addi x0,x0,0), zero-extended or truncated to WORD_BITWIDTH.
- Undefined: bubble value is all zeros.
- The macro affects only the empty-queue and reset value of if_id_instruction.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> outputs change immediately, with no clock edge: id_valid=0, occupancy=0, if_ready=1, id_wt_pc=0, if_id_instruction=0 (or 32'h00000013 with macro).
- Single pass: push pc=0x100, instr=0x00500093 with hz_stall=0 -> next cycle id_valid=1, id_wt_pc=0x100, if_id_instruction=0x00500093; following cycle empty.
- Fill under stall:
  - Hold hz_stall=1 and push pc 0x0,0x4,0x8,0xC (DEPTH=4) -> occupancy=4, if_ready=0, head pc=0x0.
  - A fifth if_valid is not accepted.
  - Release the stall -> pops in order 0x0,0x4,0x8,0xC.
- Wrap-around: stream 10 consecutive words with one pop and one push per cycle -> occupancy constant; output order matches input order across pointer wrap.
- Flush priority: occupancy=3, assert flush together with if_valid=1 and hz_stall=0 -> next cycle occupancy=0, id_valid=0, no entry from that cycle retained.
- Reset mid-operation: occupancy=2, assert rst between edges -> outputs return to reset values without a clock edge; after release, the first push appears normally.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry in-order instruction queue between fetch (IF) and decode (ID).
// Decouples fetch from decode stalls, supports a synchronous flush for redirects, and
// presents a bubble on the head outputs whenever the queue is empty.
// Optional build macro IF_ID_QUEUE_BUBBLE_NOP_EN: when defined, the empty/reset value of
// if_id_instruction is the RV32I NOP (addi x0,x0,0); otherwise it is all zeros.
module if_id_queue #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int WORD_BITWIDTH    = 32,
    parameter int DEPTH            = 4,
    parameter int CNT_BITWIDTH     = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [WORD_BITWIDTH-1:0] pc,
    input  logic [WORD_BITWIDTH-1:0] instruction,
    input  logic                     hz_stall,
    input  logic                     flush,
    output logic                     id_valid,
    output logic [WORD_BITWIDTH-1:0] id_wt_pc,
    output logic [WORD_BITWIDTH-1:0] if_id_instruction,
    output logic [CNT_BITWIDTH-1:0]  occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_BITWIDTH-1:0] FULL_CNT = CNT_BITWIDTH'(DEPTH);

`ifdef IF_ID_QUEUE_BUBBLE_NOP_EN
    localparam logic [WORD_BITWIDTH-1:0] BUBBLE = WORD_BITWIDTH'(32'h0000_0013);
`else
    localparam logic [WORD_BITWIDTH-1:0] BUBBLE = '0;
`endif

    // Register-index width is kept only so the parameter list matches the old IF/ID register.
    logic [31:0] unused_reg_num;
    assign unused_reg_num = 32'(REG_NUM_BITWIDTH);

    logic [WORD_BITWIDTH-1:0] pc_mem    [DEPTH];
    logic [WORD_BITWIDTH-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_BITWIDTH-1:0]  count;
    logic                     push;
    logic                     pop;

    // Handshake flags come from registered count only, so stall/flush never reach if_ready.
    assign if_ready  = (count != FULL_CNT);
    assign id_valid  = (count != '0);
    assign occupancy = count;

    // Flush wins over both sides of the queue.
    assign push = if_valid & if_ready & ~flush;
    assign pop  = id_valid & ~hz_stall & ~flush;

    // Head outputs fall back to the bubble when nothing is queued.
    assign id_wt_pc          = id_valid ? pc_mem[rd_ptr]    : '0;
    assign if_id_instruction = id_valid ? instr_mem[rd_ptr] : BUBBLE;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_BITWIDTH'(1);
            else if (pop && !push) count <= count - CNT_BITWIDTH'(1);
        end
    end

    // Entry storage; cleared on reset, written at wr_ptr on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= instruction;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed + randomized check of if_id_queue against a queue-based model.
module tb_if_id_queue;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef IF_ID_QUEUE_BUBBLE_NOP_EN
    localparam logic [W-1:0] BUBBLE = 32'h0000_0013;
`else
    localparam logic [W-1:0] BUBBLE = 32'h0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_valid = 1'b0;
    logic          if_ready;
    logic [W-1:0]  pc = '0;
    logic [W-1:0]  instruction = '0;
    logic          hz_stall = 1'b0;
    logic          flush = 1'b0;
    logic          id_valid;
    logic [W-1:0]  id_wt_pc;
    logic [W-1:0]  if_id_instruction;
    logic [CW-1:0] occupancy;

    if_id_queue #(.REG_NUM_BITWIDTH(5), .WORD_BITWIDTH(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .pc(pc), .instruction(instruction), .hz_stall(hz_stall), .flush(flush),
        .id_valid(id_valid), .id_wt_pc(id_wt_pc), .if_id_instruction(if_id_instruction),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] ins;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every output against what the queue model says should be at the head.
    task automatic check_outputs();
        int n;
        n = q.size();
        chk("id_valid", 64'(id_valid), 64'(n != 0));
        chk("occupancy", 64'(occupancy), 64'(n));
        chk("if_ready", 64'(if_ready), 64'(n != DEPTH));
        chk("id_wt_pc", 64'(id_wt_pc), (n != 0) ? 64'(q[0].pc) : 64'h0);
        chk("if_id_instr", 64'(if_id_instruction), (n != 0) ? 64'(q[0].ins) : 64'(BUBBLE));
    endtask

    // Queue semantics evaluated on the pre-edge model state and current inputs.
    task automatic model_update();
        bit do_push, do_pop;
        do_push = if_valid && (q.size() != DEPTH) && !flush;
        do_pop  = (q.size() != 0) && !hz_stall && !flush;
        if (flush) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back('{pc: pc, ins: instruction});
        end
    endtask

    task automatic step();
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] p, input logic [W-1:0] i,
                         input logic st, input logic fl);
        if_valid = v; pc = p; instruction = i; hz_stall = st; flush = fl;
    endtask

    initial begin
        // Reset asserted before any clock edge: outputs must already show the idle state.
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", 64'(id_valid), 64'h0);
        chk("rst_occ", 64'(occupancy), 64'h0);
        chk("rst_ready", 64'(if_ready), 64'h1);
        chk("rst_pc", 64'(id_wt_pc), 64'h0);
        chk("rst_instr", 64'(if_id_instruction), 64'(BUBBLE));
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        step();

        // Single pass through an empty queue.
        drive(1, 32'h100, 32'h0050_0093, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("pass_valid", 64'(id_valid), 64'h1);
        chk("pass_pc", 64'(id_wt_pc), 64'h100);
        chk("pass_instr", 64'(if_id_instruction), 64'h0050_0093);
        step();
        chk("pass_empty", 64'(id_valid), 64'h0);

        // Fill under stall, then a refused fifth push, then ordered drain.
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 32'(4 * k), 32'hA000_0000 + 32'(k), 1, 0);
            step();
        end
        chk("fill_occ", 64'(occupancy), 64'(DEPTH));
        chk("fill_ready", 64'(if_ready), 64'h0);
        chk("fill_head", 64'(id_wt_pc), 64'h0);
        drive(1, 32'h10, 32'hDEAD_BEEF, 1, 0);
        step();
        chk("fifth_occ", 64'(occupancy), 64'(DEPTH));
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) begin
            chk("drain_pc", 64'(id_wt_pc), 64'(4 * k));
            step();
        end
        chk("drain_empty", 64'(occupancy), 64'h0);

        // Wrap-around: two entries prefilled, then push+pop every cycle.
        drive(1, 32'h200, 32'hB000_0000, 1, 0); step();
        drive(1, 32'h204, 32'hB000_0001, 1, 0); step();
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h208 + 32'(4 * k), 32'hB000_0002 + 32'(k), 0, 0);
            chk("wrap_occ", 64'(occupancy), 64'h2);
            chk("wrap_pc", 64'(id_wt_pc), 64'(32'h200 + 32'(4 * k)));
            step();
        end
        drive(0, 0, 0, 0, 0);
        step(); step();

        // Flush beats a simultaneous push and pop.
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h400 + 32'(4 * k), 32'hC000_0000 + 32'(k), 1, 0);
            step();
        end
        chk("preflush_occ", 64'(occupancy), 64'h3);
        drive(1, 32'h40C, 32'hC000_0003, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        chk("flush_occ", 64'(occupancy), 64'h0);
        chk("flush_valid", 64'(id_valid), 64'h0);
        step();

        // Reset between edges with two entries queued.
        drive(1, 32'h500, 32'hD000_0000, 1, 0); step();
        drive(1, 32'h504, 32'hD000_0001, 1, 0); step();
        drive(0, 0, 0, 0, 0);
        chk("prerst_occ", 64'(occupancy), 64'h2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_occ", 64'(occupancy), 64'h0);
        chk("midrst_valid", 64'(id_valid), 64'h0);
        chk("midrst_ready", 64'(if_ready), 64'h1);
        chk("midrst_pc", 64'(id_wt_pc), 64'h0);
        chk("midrst_instr", 64'(if_id_instruction), 64'(BUBBLE));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h300, 32'h0010_0113, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("postrst_pc", 64'(id_wt_pc), 64'h300);
        chk("postrst_instr", 64'(if_id_instruction), 64'h0010_0113);
        step();

        // Randomized traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom,
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
            step();
        end
        drive(0, 0, 0, 0, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
